cart_mem_arb: RTL

CART_MEM_ARB -- requirements
Module: cart_mem_arb

---
 rtl/cart_mem_arb.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/cart_mem_arb.sv
// Cartridge memory arbiter: buffers ROM download bytes into a small write
// FIFO and shares a single SDRAM byte port between download writes and
// console cartridge reads. Writes always win; reads are cached by a
// one-entry address tag so repeated fetches of the same byte skip SDRAM.
module cart_mem_arb #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic        dl_overflow,
  input  logic        cart_rd,
  input  logic [19:0] cart_addr,
  output logic [7:0]  cart_data,
  output logic        cart_valid,
  output logic [5:0]  cart_pages,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [7:0]  mem_dout,
  input  logic        mem_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_ISSUE = 3'd1;
  localparam logic [2:0] S_WR_WAIT  = 3'd2;
  localparam logic [2:0] S_RD_ISSUE = 3'd3;
  localparam logic [2:0] S_RD_WAIT  = 3'd4;

  logic [32:0]   r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_state;
  logic          r_skip;
  logic [19:0]   r_tag;
  logic [19:0]   r_pend_tag;
  logic          r_tag_valid;
  logic [7:0]    r_cart_data;
  logic          r_cart_valid;
  logic [5:0]    r_cart_pages;
  logic          r_overflow;
  logic [24:0]   r_mem_addr;
  logic [7:0]    r_mem_din;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_tag_hit;
  logic          w_rd_pend;
  logic          w_hit;
  logic          w_wr_go;
  logic          w_rd_go;
  logic          w_rd_done;
  logic [32:0]   w_head;

  // The head entry is only popped in WR_ISSUE, so a full FIFO can still take
  // a byte in that cycle: the freed slot absorbs it.
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = (r_state == S_WR_ISSUE);
  assign w_push    = dl_wr && (!w_full || w_pop);
  assign w_drop    = dl_wr && !w_push;
  assign w_head    = r_fifo[r_rd_ptr];

  assign w_tag_hit = r_tag_valid && (cart_addr == r_tag);
  assign w_rd_pend = cart_rd && !w_tag_hit;
  assign w_hit     = cart_rd && w_tag_hit && !dl_active && (r_state == S_IDLE);
  assign w_wr_go   = (r_state == S_IDLE) && !w_empty && mem_ready;
  assign w_rd_go   = (r_state == S_IDLE) && w_empty && !dl_active && mem_ready && w_rd_pend;
  assign w_rd_done = (r_state == S_RD_WAIT) && !r_skip && mem_ready;

  assign dl_wait     = (r_count >= CW'(FIFO_DEPTH - 1));
  assign dl_overflow = r_overflow;
  assign cart_data   = r_cart_data;
  assign cart_valid  = r_cart_valid;
  assign cart_pages  = r_cart_pages;
  assign mem_addr    = r_mem_addr;
  assign mem_din     = r_mem_din;
  assign mem_we      = (r_state == S_WR_ISSUE);
  assign mem_rd      = (r_state == S_RD_ISSUE);

  // Download byte storage; contents need no reset since r_count gates reads.
  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {dl_addr, dl_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power of two.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Downloader status: page count of the last stored byte and sticky drop flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cart_pages <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push) r_cart_pages <= dl_addr[19:14];
      if (w_drop) r_overflow   <= 1'b1;
    end
  end

  // Port sequencer: address/data are loaded on leaving IDLE so they are stable
  // for the whole strobe cycle; the wait states ignore the cycle right after
  // the strobe because mem_ready has not dropped yet.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_skip     <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_go) begin
            r_state    <= S_WR_ISSUE;
            r_mem_addr <= w_head[32:8];
            r_mem_din  <= w_head[7:0];
          end else if (w_rd_go) begin
            r_state    <= S_RD_ISSUE;
            r_mem_addr <= {5'b0, cart_addr};
          end
        end
        S_WR_ISSUE: begin
          r_state <= S_WR_WAIT;
          r_skip  <= 1'b1;
        end
        S_RD_ISSUE: begin
          r_state <= S_RD_WAIT;
          r_skip  <= 1'b1;
        end
        S_WR_WAIT, S_RD_WAIT: begin
          if (r_skip) begin
            r_skip <= 1'b0;
          end else if (mem_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read tag and console return path; a download in progress always
  // invalidates the tag, even if a read completes in the same cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_tag        <= '0;
      r_pend_tag   <= '0;
      r_tag_valid  <= 1'b0;
      r_cart_data  <= '0;
      r_cart_valid <= 1'b0;
    end else begin
      r_cart_valid <= w_hit || w_rd_done;
      if (w_rd_go) r_pend_tag <= cart_addr;
      if (w_rd_done) begin
        r_cart_data <= mem_dout;
        r_tag       <= r_pend_tag;
      end
      if (dl_active) begin
        r_tag_valid <= 1'b0;
      end else if (w_rd_done) begin
        r_tag_valid <= 1'b1;
      end
    end
  end

endmodule
